// File: rtl/calc_pkg.sv
// Shared encodings and defaults for the calc_engine slice.
package calc_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREGS = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;
endpackage

// File: rtl/calc_divider.sv
// Restoring unsigned divider, one quotient bit per clock, WIDTH steps after start.
// done_o flags the final step; quotient_o/remainder_o carry that step's values.
module calc_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;

  // Bit WIDTH of the difference is the borrow: clear means the divisor fits.
  assign shifted     = {rem_q, quo_q[WIDTH-1]};
  assign diff        = shifted - {1'b0, dvs_q};
  assign fits        = ~diff[WIDTH];
  assign remainder_o = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quotient_o  = {quo_q[WIDTH-2:0], fits};
  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      cnt_q  <= CNT_W'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quotient_o;
      rem_q <= remainder_o;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/calc_engine.sv
// Handshaked add/sub/mul/div engine with last-result register and a small result store.
// CALC_DIV_EN enables the iterative divider; without it op 11 completes at once with error set.
module calc_engine
  import calc_pkg::*;
#(
  parameter int  WIDTH  = DEF_WIDTH,
  parameter int  NREGS  = DEF_NREGS,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  remainder,
  output logic              negative,
  output logic              overflow,
  output logic              error,
  input  logic              st_en,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NREGS-1:0]  occupied
);
  state_e             state_q, state_d;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   result_q, rem_q;
  logic               neg_q, ovf_q, err_q, last_vld_q;
  logic               accept, cap;
  logic [WIDTH-1:0]   c_res, c_rem;
  logic               c_neg, c_ovf, c_err;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   slot_q [NREGS];
  logic [NREGS-1:0]   occ_q;

  assign accept = op_valid && op_ready;
  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  assign prod   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

`ifdef CALC_DIV_EN
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  // Started on the accepting edge so the WIDTH steps fill exactly the CALC cycles.
  calc_divider #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (accept && (op_code == OP_DIV) && (op_b != '0)),
    .dividend_i  (op_a),
    .divisor_i   (op_b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    cap       = 1'b0;
    c_res     = '0;
    c_rem     = '0;
    c_neg     = 1'b0;
    c_ovf     = 1'b0;
    c_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_d = CALC;
      end
      CALC: begin
        cap     = 1'b1;
        state_d = DONE;
        case (op_q)
          OP_ADD: begin
            c_res = sum[WIDTH-1:0];
            c_ovf = sum[WIDTH];
          end
          OP_SUB: begin
            if (a_q >= b_q) c_res = a_q - b_q;
            else begin
              c_res = b_q - a_q;
              c_neg = 1'b1;
            end
          end
          OP_MUL: begin
            c_res = prod[WIDTH-1:0];
            c_ovf = |prod[2*WIDTH-1:WIDTH];
          end
          default: begin
`ifdef CALC_DIV_EN
            if (b_q == '0) begin
              c_res = '1;
              c_rem = a_q;
              c_err = 1'b1;
            end else begin
              c_res = div_quo;
              c_rem = div_rem;
              cap   = div_done;
              if (div_busy && !div_done) state_d = CALC;
            end
`else
            c_err = 1'b1;
`endif
          end
        endcase
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      last_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op_e'(op_code);
        a_q  <= op_a;
        b_q  <= op_b;
      end
      if (cap) begin
        result_q   <= c_res;
        rem_q      <= c_rem;
        neg_q      <= c_neg;
        ovf_q      <= c_ovf;
        err_q      <= c_err;
        last_vld_q <= 1'b1;
      end
    end
  end

  // Clear has priority over store; nothing is stored before the first completion.
  always_ff @(posedge clk) begin
    if (!rst_n)                        occ_q <= '0;
    else if (clr_en)                   occ_q <= '0;
    else if (st_en && last_vld_q)      occ_q[st_addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clr_en && st_en && last_vld_q) slot_q[st_addr] <= result_q;
  end

  assign rd_data   = occ_q[rd_addr] ? slot_q[rd_addr] : '0;
  assign occupied  = occ_q;
  assign result    = result_q;
  assign remainder = rem_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign error     = err_q;
endmodule

// File: tb/tb_calc_engine.sv
// Bench for calc_engine: table of operations with a scoreboard queue, plus hand-written
// sequences for backpressure, store/clear and reset during an operation.
module tb_calc_engine;
  import calc_pkg::*;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0, op_ready;
  logic [1:0]    op_code = '0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [W-1:0]  result, remainder;
  logic          negative, overflow, error;
  logic          st_en = 1'b0, clr_en = 1'b0;
  logic [AW-1:0] st_addr = '0, rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic [N-1:0]  occupied;

  calc_engine #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .remainder(remainder), .negative(negative), .overflow(overflow), .error(error),
    .st_en(st_en), .st_addr(st_addr), .clr_en(clr_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .occupied(occupied)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, res, rem;
    logic         neg, ovf, err;
    int           lat;
  } vec_t;

  vec_t tbl [12];
  vec_t sb [$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                              logic [W-1:0] res, logic [W-1:0] rem,
                              logic neg, logic ovf, logic err, int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.rem = rem;
    v.neg = neg; v.ovf = ovf; v.err = err; v.lat = lat;
    return v;
  endfunction

  // Reference behaviour computed with wide native arithmetic.
  function automatic vec_t model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    vec_t v;
    logic [63:0] p;
    logic [32:0] s;
    v = mk(op, a, b, '0, '0, 1'b0, 1'b0, 1'b0, 2);
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; v.res = s[31:0]; v.ovf = s[32]; end
      2'b01: begin
        if (a >= b) v.res = a - b;
        else begin v.res = b - a; v.neg = 1'b1; end
      end
      2'b10: begin p = 64'(a) * 64'(b); v.res = p[31:0]; v.ovf = (p[63:32] != 0); end
      default: begin
`ifdef CALC_DIV_EN
        if (b == 0) begin v.res = '1; v.rem = a; v.err = 1'b1; end
        else begin v.res = a / b; v.rem = a % b; v.lat = W + 1; end
`else
        v.err = 1'b1;
`endif
      end
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      if (op_ready) return;
      @(negedge clk);
    end
    chk("op_ready_timeout", {63'd0, op_ready}, 64'd1);
  endtask

  task automatic pulse(input logic st, input logic clr, input logic [AW-1:0] addr);
    st_en = st; clr_en = clr; st_addr = addr;
    @(posedge clk);
    @(negedge clk);
    st_en = 1'b0; clr_en = 1'b0;
  endtask

  task automatic compare_out(input vec_t e, input string tag);
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_remainder"}, remainder, e.rem);
    chk({tag, "_negative"}, negative, e.neg);
    chk({tag, "_overflow"}, overflow, e.ovf);
    chk({tag, "_error"}, error, e.err);
  endtask

  task automatic run_op(input vec_t v, input int hold);
    int   lat;
    bit   seen;
    vec_t e;
    wait_ready();
    op_valid = 1'b1; op_code = v.op; op_a = v.a; op_b = v.b;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; op_code = 2'($urandom_range(0, 3));
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (res_valid) begin seen = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    if (!seen) begin
      chk("res_valid_timeout", {63'd0, res_valid}, 64'd1);
    end else begin
      e = sb.pop_front();
      compare_out(e, "op");
      chk("latency", lat, e.lat);
      repeat (hold) @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_valid_after_take", {63'd0, res_valid}, 64'd0);
      chk("op_ready_after_take", {63'd0, op_ready}, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t e;
    bit   rv_seen;

    tbl[0] = mk(2'b00, 32'hFFFFFFFF, 2, 1, 0, 0, 1, 0, 2);
    tbl[1] = mk(2'b00, 1, 2, 3, 0, 0, 0, 0, 2);
    tbl[2] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[3] = mk(2'b01, 5, 9, 4, 0, 1, 0, 0, 2);
    tbl[4] = mk(2'b01, 9, 5, 4, 0, 0, 0, 0, 2);
    tbl[5] = mk(2'b01, 7, 7, 0, 0, 0, 0, 0, 2);
    tbl[6] = mk(2'b10, 32'h10000, 32'h10000, 0, 0, 0, 1, 0, 2);
    tbl[7] = mk(2'b10, 32'hFFFF, 32'hFFFF, 32'hFFFE0001, 0, 0, 0, 0, 2);
    tbl[8] = mk(2'b10, 3, 5, 15, 0, 0, 0, 0, 2);
`ifdef CALC_DIV_EN
    tbl[9]  = mk(2'b11, 100, 7, 14, 2, 0, 0, 0, 33);
    tbl[10] = mk(2'b11, 9, 0, 32'hFFFFFFFF, 9, 0, 0, 1, 2);
    tbl[11] = mk(2'b11, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 33);
`else
    tbl[9]  = mk(2'b11, 100, 7, 0, 0, 0, 0, 1, 2);
    tbl[10] = mk(2'b11, 9, 0, 0, 0, 0, 0, 1, 2);
    tbl[11] = mk(2'b11, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 1, 2);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_op_ready", {63'd0, op_ready}, 64'd1);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    compare_out(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "rst");
    chk("rst_occupied", occupied, 0);

    pulse(1'b1, 1'b0, 3'd1);
    chk("store_before_op_occupied", occupied, 0);

    foreach (tbl[i]) run_op(tbl[i], i % 3);
    for (int i = 0; i < 8; i++) run_op(model(2'(i % 4), $urandom, $urandom), 0);

    // Backpressure: DONE must hold and refuse new work while res_ready is low.
    wait_ready();
    op_valid = 1'b1; op_code = 2'b00; op_a = 3; op_b = 4;
    sb.push_back(model(2'b00, 3, 4));
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    chk("hold_res_valid_rise", {63'd0, res_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      op_valid = 1'b1; op_code = 2'b10; op_a = 32'h1234; op_b = 32'h99;
      chk("hold_result", result, 7);
      chk("hold_op_ready", {63'd0, op_ready}, 64'd0);
      chk("hold_res_valid", {63'd0, res_valid}, 64'd1);
      @(negedge clk);
    end
    op_valid = 1'b0;
    e = sb.pop_front();
    compare_out(e, "hold");
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_no_new_op", {63'd0, res_valid}, 64'd0);
    chk("hold_last_result", result, 7);

    pulse(1'b1, 1'b0, 3'd3);
    rd_addr = 3'd3; #1;
    chk("store_occupied", occupied, 8'h08);
    chk("store_rd_data", rd_data, 7);
    rd_addr = 3'd2; #1;
    chk("empty_rd_data", rd_data, 0);
    @(negedge clk);
    pulse(1'b1, 1'b1, 3'd5);
    rd_addr = 3'd3; #1;
    chk("clr_wins_occupied", occupied, 0);
    chk("clr_wins_rd_data", rd_data, 0);
    rd_addr = 3'd5; #1;
    chk("clr_wins_slot5", rd_data, 0);
    @(negedge clk);

    // Reset while an operation is in flight must abort it with no result.
    wait_ready();
    op_valid = 1'b1; op_code = 2'b11; op_a = 100; op_b = 7;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
`ifdef CALC_DIV_EN
    repeat (5) @(negedge clk);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) rv_seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_res_valid", {63'd0, rv_seen}, 64'd0);
    chk("abort_result_cleared", result, 0);
    chk("abort_error_cleared", {63'd0, error}, 64'd0);
    pulse(1'b1, 1'b0, 3'd2);
    chk("store_after_reset_ignored", occupied, 0);

    run_op(model(2'b01, 20, 5), 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>=4).
REQ-002 Parameter NREGS, default 8, result-store depth (power of two, >=2); ADDR_W = log2(NREGS), derived.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 op_valid  in  1  operation request; op_ready  out  1  engine accepts request.
REQ-006 op_code  in  2  00 add, 01 sub, 10 mul, 11 div; op_a, op_b  in  WIDTH  unsigned operands.
REQ-007 res_valid  out  1  result available; res_ready  in  1  consumer takes result.
REQ-008 result, remainder  out  WIDTH  result magnitude and division remainder.
REQ-009 negative, overflow, error  out  1  sign of sub result, overflow, divide-by-zero.
REQ-010 st_en  in  1  store last result; st_addr  in  ADDR_W  store slot; clr_en  in  1  clear all slots.
REQ-011 rd_addr  in  ADDR_W; rd_data  out  WIDTH  slot contents; occupied  out  NREGS  slot-valid bitmap.

Function
REQ-012 FSM states IDLE, CALC, DONE; op_ready=1 only in IDLE; res_valid=1 only in DONE.
REQ-013 Handshake op_valid&&op_ready at edge N latches op_code/op_a/op_b and enters CALC; later operand changes ignored.
REQ-014 add/sub/mul: CALC lasts one cycle; res_valid high from edge N+2 (after N+1 computes).
REQ-015 add: result = (a+b) mod 2^WIDTH; overflow = carry out.
REQ-016 sub: a>=b gives a-b, negative=0; a<b gives b-a, negative=1; overflow=0.
REQ-017 mul: result = low WIDTH bits of a*b; overflow=1 iff high WIDTH bits nonzero.
REQ-018 div, b!=0: restoring divide, one quotient bit per cycle, WIDTH cycles in CALC; res_valid from edge N+WIDTH+1; result=a/b, remainder=a%b.
REQ-019 div, b=0: one CALC cycle; result all ones, remainder=a, error=1.
REQ-020 remainder=0 for non-div ops; negative/error=0 unless stated; flags valid with res_valid.
REQ-021 DONE holds result/flags stable until res_valid&&res_ready, then IDLE; op_ready high the following cycle (no same-edge accept).
REQ-022 result/flags remain readable after DONE exits until the next completion (last result register).
REQ-023 st_en writes last result into slot st_addr and sets occupied[st_addr]; ignored if no op has completed since reset.
REQ-024 clr_en clears all occupied bits; clr_en and st_en same cycle: clear wins, no write.
REQ-025 rd_data combinational: slot contents if occupied[rd_addr], else 0; write visible next cycle.
REQ-026 Store/clear/read operate in any FSM state.

Reset
REQ-027 rst_n=0 at a rising edge: state IDLE, op_ready=1 after release, res_valid=0, result/remainder/flags=0, occupied=0, last-result-valid cleared.
REQ-028 Reset mid-division aborts the operation; no partial result ever appears.

Configuration
REQ-029 Macro CALC_DIV_EN: defined, division per REQ-018/019; undefined, no divider logic, op 11 completes in one CALC cycle with result=0, remainder=0, error=1.

Structure
REQ-030 Package calc_pkg holds op_code encodings, FSM state type, default WIDTH/NREGS constants.
REQ-031 Divider is sub-module calc_divider (start/busy/done, quotient/remainder), instantiated only under CALC_DIV_EN.

Verification
REQ-032 WIDTH=32: add 0xFFFFFFFF+2 -> result 1, overflow 1, res_valid at handshake edge+2.
REQ-033 sub 5-9 -> result 4, negative 1; mul 0x10000*0x10000 -> result 0, overflow 1.
REQ-034 div 100/7 -> result 14, remainder 2, res_valid exactly 33 edges after handshake; div 9/0 -> 0xFFFFFFFF, remainder 9, error 1.
REQ-035 res_ready held low 10 cycles -> result stable, op_ready 0, new op_valid ignored.
REQ-036 store slot 3 then st_en+clr_en together -> occupied 0, rd_data 0; rst_n low mid-div -> res_valid never rises for that op.
